// File: rtl/uart_str_tx_if.sv
// uart_str_tx_if: request/status bundle between the pattern control block
// (master) and the string UART transmitter (slave).
interface uart_str_tx_if;
    logic        en_uart;  // send request, level; rising edge starts a string
    logic [79:0] tx_data;  // ASCII string, right-justified, first char highest
    logic [5:0]  tx_len;   // characters to send
    logic        tx_busy;  // string in flight
    logic        tx_done;  // one-cycle pulse at the end of the last stop bit

    modport master (
        output en_uart,
        output tx_data,
        output tx_len,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  en_uart,
        input  tx_data,
        input  tx_len,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_str_tx.sv
// uart_str_tx: serialises a right-justified ASCII string onto a UART line,
// 8 data bits LSB first, one stop bit, no idle gap between characters.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// before the stop bit (11-bit frames instead of 10).
module uart_str_tx #(
    parameter int BAUD_DIV = 703,
    parameter int MAXLEN   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_str_tx_if.slave     bus,
    output logic             tx
);
    localparam int REM_W = $clog2(MAXLEN + 1);
    typedef logic [REM_W-1:0] rem_t;
    localparam logic [15:0] DIV_M1  = 16'(BAUD_DIV - 1);
    localparam logic [5:0]  MAX_LEN = 6'(MAXLEN);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state;
    logic [15:0] cnt;        // cycles left in the current bit, minus one
    logic [2:0]  bit_idx;    // data bit currently on the line
    rem_t        rem;        // characters left, including the one on the line
    logic [7:0]  cur_byte;   // character currently being shifted out
    logic [79:0] shadow;     // string captured at the start request
    logic        en_d;       // en_uart delayed for edge detection
    logic        busy;
    logic        done;

    rem_t        start_len;
    logic [7:0]  start_byte;

    // Clamp the requested length to what fits in the string register.
    function automatic rem_t clamp_len(input logic [5:0] l);
        if (l > MAX_LEN)
            return rem_t'(MAXLEN);
        return rem_t'(l);
    endfunction

    // Character idx counted from the least significant byte of the string.
    function automatic logic [7:0] byte_at(input logic [79:0] data, input rem_t idx);
        logic [79:0] s;
        s = data >> (int'(idx) * 8);
        return s[7:0];
    endfunction

    // Length and first character of a string that would start this cycle.
    always_comb begin
        start_len  = clamp_len(bus.tx_len);
        start_byte = byte_at(bus.tx_data, start_len - rem_t'(1));
    end

    // Frame sequencer: every bit lasts BAUD_DIV cycles; line and status are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            rem      <= '0;
            cur_byte <= '0;
            shadow   <= '0;
            en_d     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx       <= 1'b1;
        end else begin
            en_d <= bus.en_uart;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en_uart && !en_d) begin
                        shadow <= bus.tx_data;
                        if (start_len == '0) begin
                            // Nothing to send: acknowledge immediately without going busy.
                            done <= 1'b1;
                        end else begin
                            state    <= START;
                            busy     <= 1'b1;
                            tx       <= 1'b0;
                            cnt      <= DIV_M1;
                            rem      <= start_len;
                            cur_byte <= start_byte;
                        end
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        state   <= DATA;
                        cnt     <= DIV_M1;
                        bit_idx <= '0;
                        tx      <= cur_byte[0];
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        cnt <= DIV_M1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= ^cur_byte;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == '0) begin
                        state <= STOP;
                        cnt   <= DIV_M1;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == '0) begin
                        if (rem > rem_t'(1)) begin
                            // Next character follows straight on with its start bit.
                            state    <= START;
                            cnt      <= DIV_M1;
                            tx       <= 1'b0;
                            rem      <= rem - rem_t'(1);
                            cur_byte <= byte_at(shadow, rem - rem_t'(2));
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx_busy = busy;
    assign bus.tx_done = done;
endmodule

// File: tb/tb_uart_str_tx.sv
// tb_uart_str_tx: directed bench for uart_str_tx with a short bit period.
// Honours UART_TX_PARITY_EN for the frame layout it expects.
module tb_uart_str_tx;
    localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic clk;
    logic rst_n;
    logic tx;
    int   checks;
    int   passes;
    logic [7:0] exp_b [0:9];

    uart_str_tx_if bus ();

    uart_str_tx #(.BAUD_DIV(BAUD), .MAXLEN(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One-cycle request pulse; returns just after the accepting edge N.
    task automatic start_pulse();
        @(posedge clk);
        #1 bus.en_uart = 1'b1;
        @(posedge clk);
        #1 bus.en_uart = 1'b0;
    endtask

    // Called just after edge N: decode n frames, then check the done cycle.
    task automatic recv(input int n, input string tag);
        int busy_cnt;
        int done_cnt;
        logic [10:0] fr;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < n; c++) begin
            fr = '0;
            for (int k = 0; k < FRAME; k++) begin
                for (int j = 0; j < BAUD; j++) begin
                    @(negedge clk);
                    busy_cnt += int'(bus.tx_busy);
                    done_cnt += int'(bus.tx_done);
                    if (j == 1) fr[k] = tx;
                end
            end
            chk($sformatf("%s_start%0d", tag, c), {31'd0, fr[0]}, 32'd0);
            chk($sformatf("%s_byte%0d", tag, c), {24'd0, fr[8:1]}, {24'd0, exp_b[c]});
`ifdef UART_TX_PARITY_EN
            chk($sformatf("%s_par%0d", tag, c), {31'd0, fr[9]}, {31'd0, ^exp_b[c]});
`endif
            chk($sformatf("%s_stop%0d", tag, c), {31'd0, fr[FRAME-1]}, 32'd1);
        end
        chk({tag, "_busy_cycles"}, busy_cnt, n * FRAME * BAUD);
        chk({tag, "_early_done"}, done_cnt, 0);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, bus.tx_done}, 32'd1);
        chk({tag, "_busy_off"}, {31'd0, bus.tx_busy}, 32'd0);
    endtask

    // Line must stay idle for the given number of cycles.
    task automatic quiet(input int cycles, input string tag);
        int act;
        act = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.tx_busy !== 1'b0 || tx !== 1'b1) act++;
        end
        chk({tag, "_quiet"}, act, 0);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst_n = 1'b0;
        bus.en_uart = 1'b0;
        bus.tx_data = '0;
        bus.tx_len  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, bus.tx_busy}, 32'd0);
        chk("rst_done", {31'd0, bus.tx_done}, 32'd0);
        rst_n = 1'b1;

        // Full ten-character status string.
        bus.tx_data = "*A08-2_V4#";
        bus.tx_len  = 6'd10;
        exp_b = '{8'h2A, 8'h41, 8'h30, 8'h38, 8'h2D, 8'h32, 8'h5F, 8'h56, 8'h34, 8'h23};
        start_pulse();
        recv(10, "s10");
        quiet(10, "s10");

        // Short string with junk above it; restart in the done cycle.
        bus.tx_data = {56'hDE_ADBE_EF00_1122, 24'h2A3123};
        bus.tx_len  = 6'd3;
        exp_b[0] = 8'h2A;
        exp_b[1] = 8'h31;
        exp_b[2] = 8'h23;
        start_pulse();
        recv(3, "s3");
        bus.en_uart = 1'b1;
        @(posedge clk);
        #1 bus.en_uart = 1'b0;
        recv(3, "s3b2b");
        quiet(10, "s3b2b");

        // Level held high with a mid-send re-edge: exactly one string.
        @(posedge clk);
        #1 bus.en_uart = 1'b1;
        @(posedge clk);
        #1;
        fork
            recv(3, "hold");
            begin
                repeat (60) @(posedge clk);
                #1 bus.en_uart = 1'b0;
                @(posedge clk);
                #1 bus.en_uart = 1'b1;
            end
        join
        quiet(1000 - 3 * FRAME * BAUD, "hold");
        bus.en_uart = 1'b0;
        quiet(5, "hold_rel");

        // Zero length: done pulse only.
        bus.tx_len = 6'd0;
        start_pulse();
        @(negedge clk);
        chk("len0_done", {31'd0, bus.tx_done}, 32'd1);
        chk("len0_busy", {31'd0, bus.tx_busy}, 32'd0);
        chk("len0_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        chk("len0_done_off", {31'd0, bus.tx_done}, 32'd0);
        quiet(10, "len0");

        // Overlong length clamps to ten characters.
        bus.tx_data = "*A08-2_V4#";
        bus.tx_len  = 6'd63;
        exp_b = '{8'h2A, 8'h41, 8'h30, 8'h38, 8'h2D, 8'h32, 8'h5F, 8'h56, 8'h34, 8'h23};
        start_pulse();
        recv(10, "len63");

        // Asynchronous reset in the middle of character 2.
        bus.tx_len = 6'd10;
        start_pulse();
        bus.tx_data = '0;
        repeat (90) @(negedge clk);
        chk("mid_tx", {31'd0, tx}, 32'd0);
        chk("mid_busy", {31'd0, bus.tx_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx", {31'd0, tx}, 32'd1);
        chk("arst_busy", {31'd0, bus.tx_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet(5, "arst");
        bus.tx_data = {56'd0, 24'h2A3123};
        bus.tx_len  = 6'd3;
        exp_b[0] = 8'h2A;
        exp_b[1] = 8'h31;
        exp_b[2] = 8'h23;
        start_pulse();
        recv(3, "post_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
